// File: rtl/qkv_tile_fetch_gen.sv
// Tile fetch engine: walks a matrix in linear or column-stride order, reads NUM_CH BRAM banks in
// lockstep and returns latency-aligned beats through a small skid FIFO with valid/ready handshake.
module qkv_tile_fetch_gen #(
    parameter int NUM_CH       = 3,
    parameter int ADDR_WIDTH   = 16,
    parameter int DATA_WIDTH   = 256,
    parameter int ORIG_ROWS    = 512,
    parameter int ORIG_COLS    = 768,
    parameter int NUM_BITS     = 8,
    parameter int TILE_FETCHES = 32,
    parameter int BRAM_LATENCY = 1,
    parameter int BASE_ADDR    = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         abort,
    input  logic                         mode,
    input  logic [NUM_CH-1:0]            ch_mask,
    input  logic [15:0]                  num_tiles,
    output logic [NUM_CH-1:0]            bram_en,
    output logic [ADDR_WIDTH-1:0]        bram_addr,
    input  logic [NUM_CH*DATA_WIDTH-1:0] bram_dout,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [NUM_CH*DATA_WIDTH-1:0] out_data,
    output logic                         out_tile_last,
    output logic                         tile_done,
    output logic                         all_done,
    output logic                         busy
);

    localparam int WPR   = ORIG_COLS * NUM_BITS / DATA_WIDTH;
    localparam int TOTAL = ORIG_ROWS * WPR;
    localparam int BW    = (TILE_FETCHES > 1) ? $clog2(TILE_FETCHES) : 1;
    localparam int DW    = NUM_CH * DATA_WIDTH;

    localparam logic [ADDR_WIDTH-1:0] BASE_A  = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [ADDR_WIDTH-1:0] WPR_A   = ADDR_WIDTH'(WPR);
    localparam logic [ADDR_WIDTH-1:0] IDX_MAX = ADDR_WIDTH'(TOTAL - 1);
    localparam logic [ADDR_WIDTH-1:0] ROW_MAX = ADDR_WIDTH'(ORIG_ROWS - 1);
    localparam logic [ADDR_WIDTH-1:0] COL_MAX = ADDR_WIDTH'(WPR - 1);
    localparam logic [BW-1:0]         BEAT_MAX = BW'(TILE_FETCHES - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                  state, state_nxt;
    logic                    mode_q;
    logic [NUM_CH-1:0]       mask_q;
    logic [15:0]             tiles_q;
    logic [15:0]             tile_cnt;
    logic [BW-1:0]           beat_cnt;
    logic [ADDR_WIDTH-1:0]   idx, row, col;
    logic [BRAM_LATENCY-1:0] vld_sr, last_sr;
    logic                    zero_done_q;

    logic [DW-1:0]           fifo_data [4];
    logic                    fifo_last [4];
    logic [1:0]              wr_ptr, rd_ptr;
    logic [2:0]              fifo_cnt;

    logic [3:0]              inflight;
    logic [3:0]              occupancy;
    logic                    start_ok, issue, beat_last, job_last;
    logic                    push, pop, final_hs;
    logic [DW-1:0]           ret_data;

    assign start_ok  = (state == IDLE) && start && !abort;
    assign beat_last = (beat_cnt == BEAT_MAX);
    assign job_last  = beat_last && (tile_cnt == tiles_q - 16'd1);

    // Reads still in the BRAM pipeline count against FIFO space, so a push can never find it full.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < BRAM_LATENCY; i++) begin
            inflight = inflight + {3'b000, vld_sr[i]};
        end
    end

    assign occupancy = {1'b0, fifo_cnt} + inflight;
    assign issue     = (state == RUN) && !abort && (occupancy < 4'd4);
    assign push      = vld_sr[BRAM_LATENCY-1] && !abort;
    assign out_valid = (fifo_cnt != 3'd0) && !abort;
    assign pop       = out_valid && out_ready;
    assign final_hs  = (state == DRAIN) && pop && (fifo_cnt == 3'd1) && (inflight == 4'd0);

    assign out_data      = out_valid ? fifo_data[rd_ptr] : '0;
    assign out_tile_last = out_valid && fifo_last[rd_ptr];
    assign tile_done     = pop && out_tile_last;
    assign all_done      = zero_done_q || final_hs;
    assign busy          = (state != IDLE);

    assign bram_en   = issue ? mask_q : '0;
    assign bram_addr = mode_q ? (BASE_A + row * WPR_A + col) : (BASE_A + idx);

    always_comb begin
        ret_data = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            if (mask_q[ch]) begin
                ret_data[ch*DATA_WIDTH +: DATA_WIDTH] = bram_dout[ch*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_ok && (num_tiles != 16'd0)) state_nxt = RUN;
            RUN:     if (issue && job_last) state_nxt = DRAIN;
            DRAIN:   if (final_hs) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (abort) begin
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            zero_done_q <= 1'b0;
            mode_q      <= 1'b0;
            mask_q      <= '0;
            tiles_q     <= '0;
            tile_cnt    <= '0;
            beat_cnt    <= '0;
            idx         <= '0;
            row         <= '0;
            col         <= '0;
            vld_sr      <= '0;
            last_sr     <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_cnt    <= '0;
        end else begin
            state       <= state_nxt;
            zero_done_q <= start_ok && (num_tiles == 16'd0);

            // Every accepted start rewinds the walk to BASE_ADDR.
            if (start_ok) begin
                mode_q   <= mode;
                mask_q   <= ch_mask;
                tiles_q  <= num_tiles;
                tile_cnt <= '0;
                beat_cnt <= '0;
                idx      <= '0;
                row      <= '0;
                col      <= '0;
            end else if (issue) begin
                beat_cnt <= beat_last ? '0 : beat_cnt + 1'b1;
                if (beat_last) begin
                    tile_cnt <= tile_cnt + 16'd1;
                end
                if (mode_q) begin
                    if (row == ROW_MAX) begin
                        row <= '0;
                        col <= (col == COL_MAX) ? '0 : col + 1'b1;
                    end else begin
                        row <= row + 1'b1;
                    end
                end else begin
                    idx <= (idx == IDX_MAX) ? '0 : idx + 1'b1;
                end
            end

            if (abort) begin
                vld_sr   <= '0;
                last_sr  <= '0;
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                fifo_cnt <= '0;
            end else begin
                for (int i = BRAM_LATENCY - 1; i > 0; i--) begin
                    vld_sr[i]  <= vld_sr[i-1];
                    last_sr[i] <= last_sr[i-1];
                end
                vld_sr[0]  <= issue;
                last_sr[0] <= issue && beat_last;
                if (push) wr_ptr <= wr_ptr + 2'd1;
                if (pop)  rd_ptr <= rd_ptr + 2'd1;
                case ({push, pop})
                    2'b10:   fifo_cnt <= fifo_cnt + 3'd1;
                    2'b01:   fifo_cnt <= fifo_cnt - 3'd1;
                    default: fifo_cnt <= fifo_cnt;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr] <= ret_data;
            fifo_last[wr_ptr] <= last_sr[BRAM_LATENCY-1];
        end
    end

endmodule

// File: tb/tb_qkv_tile_fetch_gen.sv
// Scoreboard bench for qkv_tile_fetch_gen: an address model predicts each read and its beat,
// which is queued on issue and compared when the beat is handed over.
module tb_qkv_tile_fetch_gen;

    localparam int NUM_CH = 3;
    localparam int DATA_WIDTH = 256;
    localparam int DW = NUM_CH * DATA_WIDTH;
    localparam int LAT = 2;
    localparam int TF = 32;
    localparam int ROWS = 512;
    localparam int WPR = 24;
    localparam int TOTAL = 12288;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    logic              clk = 1'b0;
    logic              rst, start, abort, mode, out_ready;
    logic [NUM_CH-1:0] ch_mask;
    logic [15:0]       num_tiles;
    logic [NUM_CH-1:0] bram_en;
    logic [15:0]       bram_addr;
    logic [DW-1:0]     bram_dout;
    logic              out_valid, out_tile_last, tile_done, all_done, busy;
    logic [DW-1:0]     out_data;

    int assert_cnt = 0;
    int fail_cnt = 0;

    always #5 clk = ~clk;

    qkv_tile_fetch_gen #(.BRAM_LATENCY(LAT)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .mode(mode),
        .ch_mask(ch_mask), .num_tiles(num_tiles), .bram_en(bram_en), .bram_addr(bram_addr),
        .bram_dout(bram_dout), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_tile_last(out_tile_last), .tile_done(tile_done), .all_done(all_done), .busy(busy)
    );

    function automatic logic [DATA_WIDTH-1:0] word_of(int ch, logic [15:0] a);
        logic [31:0] w;
        w = {4'(ch + 1), 12'h5A3, a};
        return {8{w}};
    endfunction

    function automatic logic [DW-1:0] exp_data(logic [NUM_CH-1:0] m, logic [15:0] a);
        logic [DW-1:0] d;
        d = '0;
        for (int ch = 0; ch < NUM_CH; ch++)
            if (m[ch]) d[ch*DATA_WIDTH +: DATA_WIDTH] = word_of(ch, a);
        return d;
    endfunction

    function automatic logic [15:0] model_addr(logic m, int n);
        if (m) return 16'(((n % ROWS) * WPR) + ((n / ROWS) % WPR));
        return 16'(n % TOTAL);
    endfunction

    // BRAM with LAT cycles of read latency; each bank only updates when enabled.
    logic [DW-1:0] bram_q1 = '0;
    logic [DW-1:0] bram_q2 = '0;
    always @(posedge clk) begin
        for (int ch = 0; ch < NUM_CH; ch++)
            if (bram_en[ch]) bram_q1[ch*DATA_WIDTH +: DATA_WIDTH] <= word_of(ch, bram_addr);
        bram_q2 <= bram_q1;
    end
    assign bram_dout = bram_q2;

    task automatic checkOutput(input string tag, input logic [DW-1:0] actual, input logic [DW-1:0] expected);
        assert_cnt++;
        if (actual !== expected) begin
            fail_cnt++;
            $display("[TB] FAIL %s: actual=%0h expected=%0h", tag, actual, expected);
        end
    endtask

    int cyc = 0;
    always @(posedge clk) cyc++;

    beat_t             sb[$];
    beat_t             mon_beat;
    logic [15:0]       mon_addr;
    logic              exp_mode;
    logic [NUM_CH-1:0] exp_mask;
    int iss_n, hs_n, td_n, ad_n, first_iss, first_vld, first_hs, last_hs;
    logic [15:0] first_addr, addr_512, addr_12287, addr_12288;
    logic              stall_q = 1'b0;
    logic [DW-1:0]     stall_data;
    logic              stall_last;

    always @(negedge clk) begin
        if (rst || abort) begin
            sb.delete();
            stall_q = 1'b0;
        end else begin
            if (stall_q) begin
                checkOutput("stall_valid", out_valid, 1'b1);
                checkOutput("stall_data", out_data, stall_data);
                checkOutput("stall_last", out_tile_last, stall_last);
            end
            if (out_valid && first_vld < 0) first_vld = cyc;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checkOutput("sb_underflow", 1'b1, 1'b0);
                end else begin
                    mon_beat = sb.pop_front();
                    checkOutput("beat_data", out_data, mon_beat.data);
                    checkOutput("beat_last", out_tile_last, mon_beat.last);
                    checkOutput("tile_done", tile_done, mon_beat.last);
                end
                if (first_hs < 0) first_hs = cyc;
                last_hs = cyc;
                hs_n++;
            end
            if (tile_done) td_n++;
            if (all_done) begin
                ad_n++;
                checkOutput("sb_empty_at_done", sb.size(), 0);
            end
            if (bram_en != '0) begin
                mon_addr = model_addr(exp_mode, iss_n);
                checkOutput("bram_en", bram_en, exp_mask);
                checkOutput("bram_addr", bram_addr, mon_addr);
                mon_beat.data = exp_data(exp_mask, mon_addr);
                mon_beat.last = ((iss_n % TF) == TF - 1);
                sb.push_back(mon_beat);
                if (iss_n == 0) first_addr = bram_addr;
                if (iss_n == 512) addr_512 = bram_addr;
                if (iss_n == 12287) addr_12287 = bram_addr;
                if (iss_n == 12288) addr_12288 = bram_addr;
                if (first_iss < 0) first_iss = cyc;
                iss_n++;
            end
            stall_q    = out_valid && !out_ready;
            stall_data = out_data;
            stall_last = out_tile_last;
        end
    end

    task automatic resetJob(input logic m, input logic [NUM_CH-1:0] mk);
        exp_mode = m;
        exp_mask = mk;
        iss_n = 0; hs_n = 0; td_n = 0; ad_n = 0;
        first_iss = -1; first_vld = -1; first_hs = -1; last_hs = -1;
        first_addr = 16'hFFFF;
        sb.delete();
    endtask

    task automatic applyStimulus(input logic m, input logic [NUM_CH-1:0] mk, input int nt,
                                 input bit rnd, input bit spurious);
        int n, limit;
        @(posedge clk); #2;
        resetJob(m, mk);
        start = 1'b1; mode = m; ch_mask = mk; num_tiles = 16'(nt); out_ready = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        n = 0;
        limit = nt * TF * 4 + 100;
        while (ad_n == 0 && n < limit) begin
            start = 1'b0;
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (spurious && n == 20) begin
                start = 1'b1; mode = ~m; num_tiles = 16'd5;
            end
            @(posedge clk); #2;
            n++;
        end
        start = 1'b0; out_ready = 1'b1;
        checkOutput("job_done_in_time", n < limit, 1'b1);
        @(negedge clk);
        checkOutput("job_issues", iss_n, nt * TF);
        checkOutput("job_beats", hs_n, nt * TF);
        checkOutput("job_tile_done", td_n, nt);
        checkOutput("job_all_done", ad_n, 1);
        checkOutput("job_idle_after", busy, 1'b0);
        checkOutput("job_first_addr", first_addr, 16'd0);
        if (!rnd) begin
            checkOutput("job_latency", first_vld - first_iss, LAT + 1);
            checkOutput("job_no_bubbles", last_hs - first_hs, nt * TF - 1);
        end
    endtask

    int n_wait, snap_iss;

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; mode = 1'b0;
        ch_mask = '0; num_tiles = '0; out_ready = 1'b0;
        resetJob(1'b0, '0);
        repeat (2) @(posedge clk);
        #2;
        checkOutput("rst_bram_en", bram_en, '0);
        checkOutput("rst_bram_addr", bram_addr, 16'd0);
        checkOutput("rst_out_valid", out_valid, 1'b0);
        checkOutput("rst_out_data", out_data, '0);
        checkOutput("rst_tile_last", out_tile_last, 1'b0);
        checkOutput("rst_tile_done", tile_done, 1'b0);
        checkOutput("rst_all_done", all_done, 1'b0);
        checkOutput("rst_busy", busy, 1'b0);
        rst = 1'b0;

        // Zero-tile job completes without ever going busy.
        @(posedge clk); #2;
        resetJob(1'b0, 3'b111);
        start = 1'b1; num_tiles = 16'd0; ch_mask = 3'b111;
        @(negedge clk);
        checkOutput("zero_done_early", all_done, 1'b0);
        checkOutput("zero_busy0", busy, 1'b0);
        @(posedge clk); #2;
        start = 1'b0;
        @(negedge clk);
        checkOutput("zero_done_pulse", all_done, 1'b1);
        checkOutput("zero_busy1", busy, 1'b0);
        @(negedge clk);
        checkOutput("zero_done_once", all_done, 1'b0);
        checkOutput("zero_busy2", busy, 1'b0);

        applyStimulus(1'b0, 3'b111, 2, 1'b0, 1'b0);
        applyStimulus(1'b1, 3'b111, 1, 1'b0, 1'b0);
        applyStimulus(1'b1, 3'b111, 17, 1'b0, 1'b0);
        checkOutput("col_beat512_addr", addr_512, 16'd1);
        applyStimulus(1'b1, 3'b111, 3, 1'b1, 1'b0);
        applyStimulus(1'b0, 3'b101, 2, 1'b1, 1'b0);
        applyStimulus(1'b0, 3'b111, 385, 1'b0, 1'b0);
        checkOutput("lin_addr_12287", addr_12287, 16'd12287);
        checkOutput("lin_wrap_addr", addr_12288, 16'd0);
        applyStimulus(1'b0, 3'b010, 1, 1'b0, 1'b0);

        // Abort after ten beats of tile 0.
        @(posedge clk); #2;
        resetJob(1'b0, 3'b111);
        start = 1'b1; mode = 1'b0; ch_mask = 3'b111; num_tiles = 16'd2; out_ready = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        n_wait = 0;
        while (hs_n < 10 && n_wait < 200) begin
            @(posedge clk); #2;
            n_wait++;
        end
        checkOutput("abort_reach_beat10", hs_n, 10);
        abort = 1'b1;
        @(posedge clk); #2;
        abort = 1'b0;
        @(negedge clk);
        checkOutput("abort_idle", busy, 1'b0);
        checkOutput("abort_no_valid", out_valid, 1'b0);
        snap_iss = iss_n;
        repeat (20) @(negedge clk);
        checkOutput("abort_no_issue", iss_n, snap_iss);
        checkOutput("abort_no_beats", hs_n, 10);
        checkOutput("abort_no_tile_done", td_n, 0);
        checkOutput("abort_no_all_done", ad_n, 0);

        // Fresh job rewinds to address 0 and ignores a start while busy.
        applyStimulus(1'b0, 3'b111, 1, 1'b0, 1'b1);

        // start and abort together: abort wins.
        @(posedge clk); #2;
        resetJob(1'b0, 3'b111);
        start = 1'b1; abort = 1'b1; num_tiles = 16'd1;
        @(posedge clk); #2;
        start = 1'b0; abort = 1'b0;
        @(negedge clk);
        checkOutput("start_abort_idle", busy, 1'b0);
        repeat (10) @(negedge clk);
        checkOutput("start_abort_no_issue", iss_n, 0);
        checkOutput("start_abort_no_done", ad_n, 0);

        // Reset in the middle of a job.
        @(posedge clk); #2;
        resetJob(1'b1, 3'b111);
        start = 1'b1; mode = 1'b1; num_tiles = 16'd2;
        @(posedge clk); #2;
        start = 1'b0;
        repeat (15) @(posedge clk);
        #2;
        rst = 1'b1;
        @(posedge clk); #2;
        checkOutput("midrst_busy", busy, 1'b0);
        checkOutput("midrst_valid", out_valid, 1'b0);
        checkOutput("midrst_en", bram_en, '0);
        checkOutput("midrst_data", out_data, '0);
        rst = 1'b0;
        snap_iss = iss_n;
        repeat (10) @(negedge clk);
        checkOutput("midrst_no_issue", iss_n, snap_iss);
        checkOutput("midrst_no_done", ad_n, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

endmodule
